// File: rtl/apb_reg_bridge_if.sv
// APB4 bus bundle between an APB requester and the apb_reg_bridge completer.
interface apb_reg_bridge_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_bridge.sv
// APB4 completer that turns each transfer into a one-cycle register request,
// waits for reg_ack (or a timeout) and answers with registered pready/pslverr.
module apb_reg_bridge #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int ADDR_SPAN = 4096,
  parameter int TIMEOUT   = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_reg_bridge_if.slave      apb,
  output logic [ADDR_W-1:0]    reg_addr,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [DATA_W/8-1:0]  wr_msk,
  output logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W-1:0]    rd_data,
  input  logic                 reg_ack
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0]  SPAN_L  = (ADDR_W + 1)'(ADDR_SPAN);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                write_r, write_s;
  logic [ADDR_W-1:0]   reg_addr_r, reg_addr_s;
  logic [DATA_W-1:0]   wr_data_r, wr_data_s;
  logic [STRB_W-1:0]   wr_msk_r, wr_msk_s;
  logic [DATA_W-1:0]   prdata_r, prdata_s;
  logic                wr_en_r, wr_en_s;
  logic                rd_en_r, rd_en_s;
  logic                pready_r, pready_s;
  logic                pslverr_r, pslverr_s;
  logic                setup_s;
  logic                dec_err_s;
  logic                to_hit_s;

  assign setup_s   = apb.psel & ~apb.penable;
  // Out-of-span or not word-aligned addresses never reach the register file.
  assign dec_err_s = ({1'b0, apb.paddr} >= SPAN_L) || (apb.paddr[LSB_W-1:0] != {LSB_W{1'b0}});
  assign to_hit_s  = TO_EN && (cnt_r == TO_LAST);

  // State and all output registers; preset discards any pending request.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      write_r    <= 1'b0;
      reg_addr_r <= {ADDR_W{1'b0}};
      wr_data_r  <= {DATA_W{1'b0}};
      wr_msk_r   <= {STRB_W{1'b0}};
      prdata_r   <= {DATA_W{1'b0}};
      wr_en_r    <= 1'b0;
      rd_en_r    <= 1'b0;
      pready_r   <= 1'b0;
      pslverr_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      write_r    <= write_s;
      reg_addr_r <= reg_addr_s;
      wr_data_r  <= wr_data_s;
      wr_msk_r   <= wr_msk_s;
      prdata_r   <= prdata_s;
      wr_en_r    <= wr_en_s;
      rd_en_r    <= rd_en_s;
      pready_r   <= pready_s;
      pslverr_r  <= pslverr_s;
    end
  end

  // Next-state decision; ack wins over a timeout on the same WAIT cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (setup_s) begin
          state_s = dec_err_s ? S_RESP : S_WAIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (reg_ack || to_hit_s) begin
          state_s = S_RESP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, request latch and wait counter.
  always_comb begin
    cnt_s      = cnt_r;
    write_s    = write_r;
    reg_addr_s = reg_addr_r;
    wr_data_s  = wr_data_r;
    wr_msk_s   = wr_msk_r;
    prdata_s   = prdata_r;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    pready_s   = 1'b0;
    pslverr_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (setup_s) begin
          write_s    = apb.pwrite;
          reg_addr_s = apb.paddr;
          wr_data_s  = apb.pwdata;
          wr_msk_s   = apb.pwrite ? apb.pstrb : {STRB_W{1'b0}};
          cnt_s      = {CNT_W{1'b0}};
          if (dec_err_s) begin
            pready_s  = 1'b1;
            pslverr_s = 1'b1;
          end else begin
            wr_en_s = apb.pwrite;
            rd_en_s = ~apb.pwrite;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_WAIT: begin
        if (reg_ack) begin
          pready_s = 1'b1;
          prdata_s = write_r ? prdata_r : rd_data;
        end else if (to_hit_s) begin
          pready_s  = 1'b1;
          pslverr_s = 1'b1;
          prdata_s  = write_r ? prdata_r : {DATA_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_RESP:  cnt_s = cnt_r;
      default: cnt_s = cnt_r;
    endcase
  end

  assign apb.prdata  = prdata_r;
  assign apb.pready  = pready_r;
  assign apb.pslverr = pslverr_r;
  assign reg_addr    = reg_addr_r;
  assign wr_data     = wr_data_r;
  assign wr_msk      = wr_msk_r;
  assign wr_en       = wr_en_r;
  assign rd_en       = rd_en_r;
endmodule

// File: tb/tb_apb_reg_bridge.sv
// Scoreboard bench for apb_reg_bridge: directed cases then random transfers,
// expectations derived from the APB timing rules and queued for a monitor.
module tb_apb_reg_bridge;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int ADDR_SPAN = 256;
  localparam int TIMEOUT   = 4;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [11:0] addr;
    logic [3:0]  msk;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int          cyc;
    bit          err;
    bit          chk_rd;
    logic [31:0] prdata;
  } resp_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [11:0] reg_addr;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  wr_msk;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        reg_ack;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_prdata = 32'h0;
  req_t        req_q[$];
  resp_t       resp_q[$];

  apb_reg_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  apb_reg_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_SPAN(ADDR_SPAN), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .preset(preset), .apb(apb),
    .reg_addr(reg_addr), .wr_en(wr_en), .rd_en(rd_en), .wr_msk(wr_msk),
    .wr_data(wr_data), .rd_data(rd_data), .reg_ack(reg_ack)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pready"},   apb.pready,  32'h0);
    chk({tag, "_pslverr"},  apb.pslverr, 32'h0);
    chk({tag, "_prdata"},   apb.prdata,  32'h0);
    chk({tag, "_wr_en"},    wr_en,       32'h0);
    chk({tag, "_rd_en"},    rd_en,       32'h0);
    chk({tag, "_reg_addr"}, reg_addr,    32'h0);
    chk({tag, "_wr_data"},  wr_data,     32'h0);
    chk({tag, "_wr_msk"},   wr_msk,      32'h0);
  endtask

  // One APB transfer; k = WAIT cycle carrying reg_ack (0 or > TIMEOUT: never in time).
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int k, input logic [31:0] rv);
    req_t  rq;
    resp_t rs;
    bit    derr, ok, done;
    int    t0;
    derr = (int'(a) >= ADDR_SPAN) || (a % 4 != 0);
    ok   = (k >= 1) && (k <= TIMEOUT);
    t0   = cyc;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
    apb.paddr = a; apb.pwdata = d; apb.pstrb = s;
    reg_ack = 1'($urandom_range(0, 1));
    rd_data = $urandom;
    if (derr) begin
      rs.cyc = t0 + 1; rs.err = 1'b1; rs.chk_rd = 1'b0; rs.prdata = m_prdata;
    end else begin
      rq.cyc = t0 + 1; rq.wr = wr; rq.addr = a; rq.msk = wr ? s : 4'h0; rq.data = d;
      req_q.push_back(rq);
      rs.cyc = t0 + 1 + (ok ? k : TIMEOUT);
      rs.err = !ok;
      rs.chk_rd = 1'b1;
      if (!wr) m_prdata = ok ? rv : 32'h0;
      rs.prdata = m_prdata;
    end
    resp_q.push_back(rs);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    done = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      if (derr || (ok && i > k) || (!ok && i > TIMEOUT)) begin
        reg_ack = 1'($urandom_range(0, 1)); rd_data = $urandom;
      end else if (ok && i == k) begin
        reg_ack = 1'b1; rd_data = rv;
      end else begin
        reg_ack = 1'b0; rd_data = $urandom;
      end
      @(negedge pclk);
      done = apb.pready;
      @(posedge pclk); #1;
    end
    chk("pready_seen", done, 32'h1);
    apb.psel = 1'b0; apb.penable = 1'b0; reg_ack = 1'b0;
  endtask

  // Monitor: every request pulse and every pready is matched against the queues.
  always @(negedge pclk) begin : monitor
    req_t  r;
    resp_t p;
    if (!preset) begin
      if (wr_en || rd_en) begin
        if (req_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_req: wr_en=%0b rd_en=%0b addr=0x%0h, expected no request (cycle %0d)",
                   wr_en, rd_en, reg_addr, cyc);
        end else begin
          r = req_q.pop_front();
          chk("req_cycle", cyc, r.cyc);
          chk("req_wr_en", wr_en, r.wr);
          chk("req_rd_en", rd_en, !r.wr);
          chk("req_addr", reg_addr, r.addr);
          chk("req_msk", wr_msk, r.msk);
          if (r.wr) chk("req_data", wr_data, r.data);
        end
      end
      if (apb.pready) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pready: pready=1 pslverr=%0b, expected idle (cycle %0d)", apb.pslverr, cyc);
        end else begin
          p = resp_q.pop_front();
          chk("resp_cycle", cyc, p.cyc);
          chk("resp_pslverr", apb.pslverr, p.err);
          if (p.chk_rd) chk("resp_prdata", apb.prdata, p.prdata);
        end
      end
    end
  end

  initial begin : stim
    req_t rq;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 12'h0; apb.pwdata = 32'h0; apb.pstrb = 4'h0;
    reg_ack = 1'b0; rd_data = 32'h0; preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check_zero("reset");
    @(posedge pclk); #1;
    preset = 1'b0;

    xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1, 32'h0);
    xfer(1'b0, 12'h020, 32'h0, 4'h0, 3, 32'h12345678);
    xfer(1'b1, 12'h030, 32'hCAFEF00D, 4'h5, 2, 32'h0);
    xfer(1'b0, 12'h030, 32'h0, 4'hF, 1, 32'h00C0FFEE);
    xfer(1'b1, 12'h002, 32'h11111111, 4'hF, 1, 32'h0);
    xfer(1'b0, 12'h104, 32'h0, 4'h0, 1, 32'h55555555);
    xfer(1'b0, 12'h040, 32'h0, 4'h0, 0, 32'h77777777);
    xfer(1'b0, 12'h044, 32'h0, 4'h0, 4, 32'h89ABCDEF);
    xfer(1'b0, 12'h048, 32'h0, 4'h0, 5, 32'h01010101);
    xfer(1'b1, 12'h0FC, 32'h22222222, 4'h0, 2, 32'h0);

    // Reset pulse during the second WAIT cycle of a read.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 12'h040;
    rq.cyc = cyc + 1; rq.wr = 1'b0; rq.addr = 12'h040; rq.msk = 4'h0; rq.data = 32'h0;
    req_q.push_back(rq);
    @(posedge pclk); #1;
    apb.penable = 1'b1; reg_ack = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge pclk);
    check_zero("mid_reset");
    m_prdata = 32'h0;
    @(posedge pclk); #1;
    xfer(1'b0, 12'h040, 32'h0, 4'h0, 1, 32'hA5A55A5A);

    for (int n = 0; n < 150; n++) begin
      logic [11:0] a;
      int          gap;
      if ($urandom_range(0, 9) == 0) a = 12'($urandom);
      else a = 12'($urandom_range(0, 63) * 4);
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 6), $urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        reg_ack = 1'($urandom_range(0, 1));
        @(posedge pclk); #1;
      end
      reg_ack = 1'b0;
    end

    repeat (3) @(posedge pclk);
    chk("req_q_empty", req_q.size(), 32'h0);
    chk("resp_q_empty", resp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
